// File: rtl/nibble_serial_adder_ctrl_if.sv
// rtl/nibble_serial_adder_ctrl_if.sv - requester-side bus of the nibble-serial adder sequencer
// Ovf exists only when SIGNED_OVF_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef SIGNED_OVF_EN
  logic             Ovf;

  modport master (output start, A, B, Cin, input busy, done, Sum, Cout, Ovf);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout, Ovf);
`else
  modport master (output start, A, B, Cin, input busy, done, Sum, Cout);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout);
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit add sequenced through one 4-bit ripple adder
// Optional signed overflow output guarded by SIGNED_OVF_EN.
module bitadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry, cout_reg;
  logic [IDXW-1:0]  idx;
  logic [3:0]       a_nib, b_nib, add_sum;
  logic             add_cout;
  logic             last_step;

  assign last_step = (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_next = S_RUN;
      S_RUN: begin
        bus.busy = 1'b1;
        if (last_step) state_next = S_DONE;
      end
      S_DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDXW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  bitadder u_bitadder (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (add_sum),
    .co (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_reg <= bus.A;
            b_reg <= bus.B;
            carry <= bus.Cin;
            idx   <= '0;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IDXW'(i)) sum_reg[4*i +: 4] <= add_sum;
          end
          carry <= add_cout;
          if (last_step) cout_reg <= add_cout;
          else           idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Sum  = sum_reg;
  assign bus.Cout = cout_reg;

`ifdef SIGNED_OVF_EN
  logic ovf_reg;
  logic msb_carry_in;

  // On the last step add_sum[3] is result bit WIDTH-1, so this recovers the carry into the MSB.
  assign msb_carry_in = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ add_sum[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf_reg <= 1'b0;
    else if (state == S_RUN && last_step) ovf_reg <= msb_carry_in ^ add_cout;
  end

  assign bus.Ovf = ovf_reg;
`endif
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - directed vector bench for nibble_serial_adder_ctrl (SIGNED_OVF_EN optional)
module tb_nibble_serial_adder_ctrl;
  logic clk;
  logic rst_n;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];
  int   n_vec;
  int   n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_ovf();
`ifdef SIGNED_OVF_EN
    return bus.Ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input bit scramble, output logic [15:0] s, output logic co,
                        output logic ov, output int lat, output int busy_cyc);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_cyc  = bus.busy ? 1 : 0;
    lat       = -1;
    s         = 'x;
    co        = 1'bx;
    ov        = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      if (scramble) begin
        bus.A   = 16'($urandom);
        bus.B   = 16'($urandom);
        bus.Cin = 1'($urandom);
      end
      @(posedge clk);
      #1;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        lat = c;
        s   = bus.Sum;
        co  = bus.Cout;
        ov  = get_ovf();
        break;
      end
    end
    @(posedge clk);
    #1;
    if (bus.busy) busy_cyc++;
    check("done_one_cycle", 32'(bus.done), 32'(0));
  endtask

  initial begin
    logic [15:0] s;
    logic        co, ov;
    int          lat, bc;

    n_vec = 0;
    n_bad = 0;
    vecs[0]  = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
    vecs[1]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[8]  = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
    vecs[10] = '{16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_sum",  32'(bus.Sum),  32'(0));
    check("rst_cout", 32'(bus.Cout), 32'(0));
    check("rst_ovf",  32'(get_ovf()), 32'(0));

    // Reset asserted after two nibble edges must clear outputs without waiting for a clock.
    @(negedge clk);
    bus.A = 16'h1234; bus.B = 16'h1111; bus.Cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_before_rst", 32'(bus.busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'(0));
    check("async_rst_done", 32'(bus.done), 32'(0));
    check("async_rst_sum",  32'(bus.Sum),  32'(0));
    check("async_rst_cout", 32'(bus.Cout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, s, co, ov, lat, bc);
    check("post_rst_sum", 32'(s), 32'(16'h0007));
    check("post_rst_lat", 32'(lat), 32'(4));

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, i[0], s, co, ov, lat, bc);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(4));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(5));
      check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].cout));
`ifdef SIGNED_OVF_EN
      check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
`endif
    end

    // start held high through RUN/DONE: ignored until the edge after DONE+1.
    @(negedge clk);
    bus.A = 16'h1000; bus.B = 16'h0234; bus.Cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.A = 16'hAAAA; bus.B = 16'h5555;
    repeat (4) @(posedge clk);
    #1;
    check("hold_first_done", 32'(bus.done), 32'(1));
    check("hold_first_sum",  32'(bus.Sum),  32'(16'h1234));
    check("hold_first_cout", 32'(bus.Cout), 32'(0));
    @(posedge clk); #1;
    check("hold_idle_busy", 32'(bus.busy), 32'(0));
    check("hold_idle_sum",  32'(bus.Sum),  32'(16'h1234));
    @(posedge clk); #1;
    check("hold_reaccept_busy", 32'(bus.busy), 32'(1));
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_no_early_done", 32'(bus.done), 32'(0));
    @(posedge clk); #1;
    check("hold_second_done", 32'(bus.done), 32'(1));
    check("hold_second_sum",  32'(bus.Sum),  32'(16'hFFFF));
    check("hold_second_cout", 32'(bus.Cout), 32'(0));
    @(posedge clk); #1;
    check("hold_second_done_drop", 32'(bus.done), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
